// File: rtl/mvt_out_stream_arbiter.sv
// mvt_out_stream_arbiter
// Merges the two HLS ap_fifo result streams (x1_out -> channel 0, x2_out -> channel 1)
// onto a narrow serial debug port. Each channel has a small FIFO. A round-robin scheduler
// picks which FIFO to drain. Each word goes out as one frame: a header nibble
// {1, zeros, ch} followed by DATA_W/OUT_W data nibbles, MSB first.
//
// Ports
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   x1_out_din/_write       channel 0 write data / strobe
//   x1_out_full_n           channel 0 FIFO not full (low during reset)
//   x2_out_din/_write       channel 1 write data / strobe
//   x2_out_full_n           channel 1 FIFO not full (low during reset)
//   data_out, data_valid    registered frame nibble and its valid flag
//   probe_out               registered pulse aligned with the last nibble of a frame
module mvt_out_stream_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] x1_out_din,
    input  logic              x1_out_write,
    output logic              x1_out_full_n,
    input  logic [DATA_W-1:0] x2_out_din,
    input  logic              x2_out_write,
    output logic              x2_out_full_n,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_valid,
    output logic              probe_out
);

    localparam int unsigned N      = DATA_W / OUT_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // FIFO storage and bookkeeping, index 0 = x1_out, index 1 = x2_out
    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [DATA_W-1:0] din      [2];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  count_q  [2];
    logic [CNT_W-1:0]  count_d  [2];
    logic [1:0]        full_n_q, full_n_d;
    logic [1:0]        push, pop, pending;

    // Scheduler / framer state
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic              cur_ch_q, cur_ch_d;
    logic              last_grant_q, last_grant_d;
    logic [OUT_W-1:0]  data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              probe_q, probe_d;
    logic              grant_ch;
    logic              take;
    logic [OUT_W-1:0]  hdr_nib;

    assign din[0] = x1_out_din;
    assign din[1] = x2_out_din;

    // full_n is registered, so a write is accepted exactly when the producer sees full_n=1
    assign push = {x2_out_write & full_n_q[1], x1_out_write & full_n_q[0]};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            pending[c] = (count_q[c] != '0);
        end
    end

    // Round-robin: on a tie, the channel that did not win last time goes next
    always_comb begin
        if (pending[0] && pending[1]) begin
            grant_ch = ~last_grant_q;
        end else begin
            grant_ch = pending[1];
        end
    end

    always_comb begin
        hdr_nib            = '0;
        hdr_nib[OUT_W-1]   = 1'b1;
        hdr_nib[0]         = cur_ch_q;
    end

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        cur_ch_d     = cur_ch_q;
        last_grant_d = last_grant_q;
        data_out_d   = '0;
        data_valid_d = 1'b0;
        probe_d      = 1'b0;
        pop          = '0;
        take         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending != '0) begin
                    take = 1'b1;
                end
            end
            ST_HDR: begin
                data_out_d   = hdr_nib;
                data_valid_d = 1'b1;
                cnt_d        = '0;
                state_d      = ST_DATA;
            end
            ST_DATA: begin
                data_out_d   = sh_q[DATA_W-1 -: OUT_W];
                data_valid_d = 1'b1;
                sh_d         = sh_q << OUT_W;
                cnt_d        = cnt_q + BEAT_W'(1);
                if (cnt_q == BEAT_W'(N - 1)) begin
                    probe_d = 1'b1;
                    // Chain straight into the next header when work is waiting
                    if (pending != '0) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            pop[grant_ch] = 1'b1;
            sh_d          = mem_q[grant_ch][rd_ptr_q[grant_ch]];
            cur_ch_d      = grant_ch;
            last_grant_d  = grant_ch;
            state_d       = ST_HDR;
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
            count_d[c]  = count_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            full_n_d[c] = (count_d[c] != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            full_n_q     <= '0;
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            cnt_q        <= '0;
            cur_ch_q     <= 1'b0;
            last_grant_q <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            probe_q      <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            full_n_q     <= full_n_d;
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            cur_ch_q     <= cur_ch_d;
            last_grant_q <= last_grant_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            probe_q      <= probe_d;
        end
    end

    // Storage needs no reset: pointers and counts are cleared instead
    always_ff @(posedge ap_clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= din[c];
            end
        end
    end

    assign x1_out_full_n = full_n_q[0];
    assign x2_out_full_n = full_n_q[1];
    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign probe_out     = probe_q;

endmodule

// File: tb/tb_mvt_out_stream_arbiter.sv
// Bench for mvt_out_stream_arbiter: accepted writes push expected words per channel,
// a negedge monitor reassembles frames and pops/compares them.
module tb_mvt_out_stream_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int N  = DW / OW;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [DW-1:0] x1_out_din = '0;
    logic          x1_out_write = 1'b0;
    logic          x1_out_full_n;
    logic [DW-1:0] x2_out_din = '0;
    logic          x2_out_write = 1'b0;
    logic          x2_out_full_n;
    logic [OW-1:0] data_out;
    logic          data_valid;
    logic          probe_out;

    mvt_out_stream_arbiter #(
        .DATA_W (DW),
        .OUT_W  (OW),
        .DEPTH  (4)
    ) u_dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .x1_out_din    (x1_out_din),
        .x1_out_write  (x1_out_write),
        .x1_out_full_n (x1_out_full_n),
        .x2_out_din    (x2_out_din),
        .x2_out_write  (x2_out_write),
        .x2_out_full_n (x2_out_full_n),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .probe_out     (probe_out)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and monitor state
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            frame_ch_q[$];
    int            frame_start_q[$];
    int            cyc = 0;
    logic          rst_seen = 1'b1;
    logic          in_frame = 1'b0;
    int            nib = 0;
    int            cur_ch = 0;
    logic [DW-1:0] word = '0;

    always @(posedge ap_clk) begin
        cyc      <= cyc + 1;
        rst_seen <= ap_rst;
    end

    always @(negedge ap_clk) begin
        if (rst_seen) begin
            check("rst_valid", data_valid, 0);
            check("rst_data", data_out, 0);
            check("rst_probe", probe_out, 0);
            check("rst_full_n1", x1_out_full_n, 0);
            check("rst_full_n2", x2_out_full_n, 0);
            in_frame = 1'b0;
            nib      = 0;
            exp_q0.delete();
            exp_q1.delete();
        end else if (data_valid) begin
            if (!in_frame) begin
                check("hdr_fmt", data_out & 4'he, 4'h8);
                check("hdr_probe", probe_out, 0);
                cur_ch   = int'(data_out[0]);
                in_frame = 1'b1;
                nib      = 0;
                word     = '0;
                frame_ch_q.push_back(cur_ch);
                frame_start_q.push_back(cyc);
            end else begin
                word = {word[DW-OW-1:0], data_out};
                check("probe_pos", probe_out, (nib == N - 1));
                nib++;
                if (nib == N) begin
                    in_frame = 1'b0;
                    if (cur_ch == 0) begin
                        check("q0_has_word", exp_q0.size() != 0, 1);
                        if (exp_q0.size() != 0) check("word_ch0", word, exp_q0.pop_front());
                    end else begin
                        check("q1_has_word", exp_q1.size() != 0, 1);
                        if (exp_q1.size() != 0) check("word_ch1", word, exp_q1.pop_front());
                    end
                end
            end
        end else begin
            check("valid_gap_in_frame", in_frame, 0);
            check("idle_probe", probe_out, 0);
            in_frame = 1'b0;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Called just after a posedge; writes only where full_n allows
    task automatic drive(input logic w1, input logic [DW-1:0] d1,
                         input logic w2, input logic [DW-1:0] d2,
                         output logic a1, output logic a2);
        a1 = w1 && x1_out_full_n;
        a2 = w2 && x2_out_full_n;
        x1_out_write = a1;
        x1_out_din   = d1;
        x2_out_write = a2;
        x2_out_din   = d2;
        if (a1) exp_q0.push_back(d1);
        if (a2) exp_q1.push_back(d2);
        tick();
        x1_out_write = 1'b0;
        x2_out_write = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || in_frame) && i < budget) begin
            tick();
            i++;
        end
        repeat (3) tick();
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        check("drain_frame", in_frame, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a1, a2;
        int   base, wc, accepted, i;
        logic saw_low;

        // T1: reset held for 3 cycles, full_n rises the cycle after release
        repeat (3) tick();
        ap_rst = 1'b0;
        tick();
        check("t1_full_n1", x1_out_full_n, 1);
        check("t1_full_n2", x2_out_full_n, 1);
        check("t1_idle_valid", data_valid, 0);

        // T3: tie right after reset, channel 0 first, no gap
        base = frame_ch_q.size();
        drive(1'b1, 32'h11111111, 1'b1, 32'h22222222, a1, a2);
        wait_drain(100);
        check("t3_frames", frame_ch_q.size() - base, 2);
        if (frame_ch_q.size() >= base + 2) begin
            check("t3_first_ch", frame_ch_q[base], 0);
            check("t3_second_ch", frame_ch_q[base+1], 1);
            check("t3_no_gap", frame_start_q[base+1] - frame_start_q[base], N + 1);
        end

        // T2: single word and its latency
        base = frame_ch_q.size();
        wc   = cyc;
        drive(1'b1, 32'hDEADBEEF, 1'b0, '0, a1, a2);
        wait_drain(100);
        check("t2_frames", frame_ch_q.size() - base, 1);
        if (frame_ch_q.size() >= base + 1) begin
            check("t2_ch", frame_ch_q[base], 0);
            check("t2_latency", frame_start_q[base] - wc, 3);
        end

        // T4: backpressure on channel 1
        accepted = 0;
        saw_low  = 1'b0;
        i        = 0;
        while (accepted < 16 && i < 400) begin
            if (!x2_out_full_n) saw_low = 1'b1;
            drive(1'b0, '0, 1'b1, DW'(accepted), a1, a2);
            if (a2) accepted++;
            i++;
        end
        check("t4_accepted", accepted, 16);
        check("t4_full_n_dropped", saw_low, 1);
        wait_drain(300);

        // T5: both channels kept loaded -> strict alternation, back to back
        base = frame_ch_q.size();
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 32'h10000000 + DW'(k), 1'b1, 32'h20000000 + DW'(k), a1, a2);
        end
        wait_drain(400);
        check("t5_enough_frames", frame_ch_q.size() - base >= 8, 1);
        if (frame_ch_q.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t5_alternate", frame_ch_q[base+k], k % 2);
                if (k > 0) check("t5_no_gap", frame_start_q[base+k] - frame_start_q[base+k-1], N + 1);
            end
        end

        // T6: reset after the 3rd data nibble with two words still queued
        drive(1'b1, 32'hCAFE0001, 1'b0, '0, a1, a2);
        drive(1'b1, 32'hCAFE0002, 1'b1, 32'hBEEF0003, a1, a2);
        i = 0;
        while (!(in_frame && nib == 3) && i < 50) begin
            tick();
            i++;
        end
        check("t6_reached_nib3", nib, 3);
        ap_rst = 1'b1;
        repeat (2) tick();
        ap_rst = 1'b0;
        tick();
        base = frame_ch_q.size();
        drive(1'b1, 32'hA5A5A5A5, 1'b0, '0, a1, a2);
        wait_drain(100);
        repeat (30) tick();
        check("t6_frames", frame_ch_q.size() - base, 1);
        if (frame_ch_q.size() >= base + 1) begin
            check("t6_ch", frame_ch_q[base], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
